wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Write-side front end for the 2-read/1-write register file.
- Merges writeback results from two producers (ALU, LSU) onto the single rd_we/rd_addr/rd_data write port.
- Uses valid/ready handshakes, round-robin arbitration and a registered output stage.
- Sits between execute/memory stages and the register file; optionally provides read-during-write forwarding to cover the register file's one-cycle synchronous read latency.

Parameters:
XLEN, 32, data width of register values
depth, 5, register address width (2^depth registers, address 0 hard-wired zero)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
alu_valid  in  1  ALU result valid
alu_ready  out  1  ALU result accepted this cycle
alu_rd_addr  in  depth  ALU destination register
alu_rd_data  in  XLEN  ALU result
lsu_valid  in  1  LSU load result valid
lsu_ready  out  1  LSU result accepted this cycle
lsu_rd_addr  in  depth  LSU destination register
lsu_rd_data  in  XLEN  LSU result
rd_we  out  1  register file write enable (registered)
rd_addr  out  depth  register file write address (registered)
rd_data  out  XLEN  register file write data (registered)

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n), sampled on rising clk edge.
- Reset values:
  - rd_we=0, rd_addr=0, rd_data=0.
  - last_grant=ALU.
  - alu_ready=lsu_ready=0 while rst_n=0; ready is combinational and gated by rst_n.
- Handshake:
  - Transfer occurs on an edge where valid && ready.
  - Producer holds valid, addr and data stable until the transfer.
  - ready never depends on the same channel's data.
- Arbitration (combinational):
  - Only ALU valid -> grant ALU.
  - Only LSU valid -> grant LSU.
  - Both valid -> grant the channel not in last_grant.
  - Granted channel's ready=1, other=0.
  - last_grant updates on every transfer.
  - First tie after reset goes to LSU.
  - When both are held valid, grants strictly alternate; max wait is 1 cycle.
- Output stage:
  - Register file never stalls, so throughput is one write per cycle.
  - Transfer at edge E -> rd_we/rd_addr/rd_data reflect it for the cycle following E.
  - No transfer at E -> rd_we=0 next cycle; rd_addr/rd_data hold previous value.
- Address 0: transfer is accepted (ready=1 per arbitration), but rd_we=0 next cycle and rd_addr/rd_data are still loaded. x0 writes are consumed, never issued.
- Neither valid: no grant, last_grant unchanged.
- Reset mid-operation: a pending (un-granted) request is not accepted; any output-stage write is dropped (rd_we=0 the cycle after reset is sampled).

Optional Feature:
- Macro: WB_FWD_EN.
- With WB_FWD_EN, extra ports:
  - rs1_addr in depth
  - rs2_addr in depth
  - fwd_rs1_hit out 1
  - fwd_rs2_hit out 1
  - fwd_data out XLEN
- Forwarding behaviour:
  - At each edge, fwd_rsN_hit <= rd_we && rd_addr!=0 && rd_addr==rsN_addr; fwd_data <= rd_data.
  - Aligns with the register file's registered rs data in the same cycle. Consumer selects fwd_data over rsN_data when the hit is set.
  - Reset: hits=0, fwd_data=0.
- Without WB_FWD_EN: ports and logic absent; read-during-write returns the old register value.

Test Plan:
- Reset: rst_n=0 for 2 cycles with both valid=1 -> both ready=0, rd_we=0, rd_addr=0, rd_data=0; after release, first cycle grants LSU.
- Single ALU: alu_valid=1, addr=3, data=0xDEADBEEF for 1 cycle -> alu_ready=1 that cycle; next cycle rd_we=1, rd_addr=3, rd_data=0xDEADBEEF; following cycle rd_we=0.
- Contention: both valid, held for 4 transfers (ALU addr 1..2, LSU addr 5..6) -> grant order LSU,ALU,LSU,ALU; rd_we=1 on 4 consecutive cycles, addrs 5,1,6,2.
- x0 drop: lsu_valid=1, addr=0, data=0x1234 -> lsu_ready=1; next cycle rd_we=0.
- Reset mid-stream: back-to-back ALU writes, rst_n=0 for 1 cycle after a transfer -> rd_we=0 the cycle after reset sampled; last_grant=ALU; next tie grants LSU.
- WB_FWD_EN: write addr 7 data 0xA5A5A5A5 with rd_we=1 while rs1_addr=7, rs2_addr=8 -> next cycle fwd_rs1_hit=1, fwd_rs2_hit=0, fwd_data=0xA5A5A5A5; repeat with addr 0 -> both hits 0.

Source files
------------

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// wb_arbiter : round-robin merge of ALU/LSU writeback onto one registered
//              register-file write port. Define WB_FWD_EN for RAW forwarding.
// Revision   : 1.0
// ============================================================================
module wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [DEPTH-1:0] alu_rd_addr,
  input  logic [XLEN-1:0]  alu_rd_data,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [DEPTH-1:0] lsu_rd_addr,
  input  logic [XLEN-1:0]  lsu_rd_data,
`ifdef WB_FWD_EN
  input  logic [DEPTH-1:0] rs1_addr,
  input  logic [DEPTH-1:0] rs2_addr,
  output logic             fwd_rs1_hit,
  output logic             fwd_rs2_hit,
  output logic [XLEN-1:0]  fwd_data,
`endif
  output logic             rd_we,
  output logic [DEPTH-1:0] rd_addr,
  output logic [XLEN-1:0]  rd_data
);

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_e;

  grant_e           last_grant_q, last_grant_d;
  logic             rd_we_q, rd_we_d;
  logic [DEPTH-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]  rd_data_q, rd_data_d;

  logic             grant_alu;
  logic             grant_lsu;
  logic             xfer;
  logic [DEPTH-1:0] sel_addr;
  logic [XLEN-1:0]  sel_data;

  always_comb begin
    // On a tie the channel that did not win last time is served.
    grant_alu = alu_valid && (!lsu_valid || (last_grant_q == GRANT_LSU));
    grant_lsu = lsu_valid && (!alu_valid || (last_grant_q == GRANT_ALU));
    alu_ready = rst_n && grant_alu;
    lsu_ready = rst_n && grant_lsu;
    xfer      = alu_ready || lsu_ready;
    sel_addr  = lsu_ready ? lsu_rd_addr : alu_rd_addr;
    sel_data  = lsu_ready ? lsu_rd_data : alu_rd_data;

    last_grant_d = last_grant_q;
    if (alu_ready) begin
      last_grant_d = GRANT_ALU;
    end else if (lsu_ready) begin
      last_grant_d = GRANT_LSU;
    end

    // x0 writes are accepted and latched but never issued.
    rd_we_d   = xfer && (sel_addr != '0);
    rd_addr_d = xfer ? sel_addr : rd_addr_q;
    rd_data_d = xfer ? sel_data : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= GRANT_ALU;
      rd_we_q      <= 1'b0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_we_q      <= rd_we_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign rd_we   = rd_we_q;
  assign rd_addr = rd_addr_q;
  assign rd_data = rd_data_q;

`ifdef WB_FWD_EN
  logic            fwd_rs1_hit_q, fwd_rs1_hit_d;
  logic            fwd_rs2_hit_q, fwd_rs2_hit_d;
  logic [XLEN-1:0] fwd_data_q, fwd_data_d;

  // Registered to line up with the register file's one-cycle read latency.
  always_comb begin
    fwd_rs1_hit_d = rd_we_q && (rd_addr_q != '0) && (rd_addr_q == rs1_addr);
    fwd_rs2_hit_d = rd_we_q && (rd_addr_q != '0) && (rd_addr_q == rs2_addr);
    fwd_data_d    = rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_rs1_hit_q <= 1'b0;
      fwd_rs2_hit_q <= 1'b0;
      fwd_data_q    <= '0;
    end else begin
      fwd_rs1_hit_q <= fwd_rs1_hit_d;
      fwd_rs2_hit_q <= fwd_rs2_hit_d;
      fwd_data_q    <= fwd_data_d;
    end
  end

  assign fwd_rs1_hit = fwd_rs1_hit_q;
  assign fwd_rs2_hit = fwd_rs2_hit_q;
  assign fwd_data    = fwd_data_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_wb_arbiter : directed and randomized checks of wb_arbiter against a
//                 cycle-level reference model of the arbitration rules.
// Revision      : 1.0
// ============================================================================
module tb_wb_arbiter;
  localparam int XLEN  = 32;
  localparam int DEPTH = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [DEPTH-1:0] alu_rd_addr, lsu_rd_addr;
  logic [XLEN-1:0]  alu_rd_data, lsu_rd_data;
  logic             rd_we;
  logic [DEPTH-1:0] rd_addr;
  logic [XLEN-1:0]  rd_data;
`ifdef WB_FWD_EN
  logic [DEPTH-1:0] rs1_addr, rs2_addr;
  logic             fwd_rs1_hit, fwd_rs2_hit;
  logic [XLEN-1:0]  fwd_data;
`endif

  int npass = 0;
  int nchk  = 0;

  // Reference model state: last winner (0 = ALU, 1 = LSU) and expected outputs.
  int               m_last;
  logic             m_we;
  logic [DEPTH-1:0] m_addr;
  logic [XLEN-1:0]  m_data;
`ifdef WB_FWD_EN
  logic             m_f1, m_f2;
  logic [XLEN-1:0]  m_fd;
`endif

  wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd_addr (alu_rd_addr),
    .alu_rd_data (alu_rd_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd_addr (lsu_rd_addr),
    .lsu_rd_data (lsu_rd_data),
`ifdef WB_FWD_EN
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .fwd_rs1_hit (fwd_rs1_hit),
    .fwd_rs2_hit (fwd_rs2_hit),
    .fwd_data    (fwd_data),
`endif
    .rd_we       (rd_we),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic m_alu_rdy();
    return rst_n && alu_valid && (!lsu_valid || m_last == 1);
  endfunction

  function automatic logic m_lsu_rdy();
    return rst_n && lsu_valid && (!alu_valid || m_last == 0);
  endfunction

  // Advance the model across one rising edge using the inputs now applied.
  task automatic m_edge();
    logic ga, gl;
    ga = m_alu_rdy();
    gl = m_lsu_rdy();
    if (!rst_n) begin
      m_last = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
`ifdef WB_FWD_EN
      m_f1 = 1'b0; m_f2 = 1'b0; m_fd = '0;
`endif
    end else begin
`ifdef WB_FWD_EN
      m_f1 = m_we && (m_addr != 0) && (m_addr == rs1_addr);
      m_f2 = m_we && (m_addr != 0) && (m_addr == rs2_addr);
      m_fd = m_data;
`endif
      if (ga) begin
        m_last = 0; m_we = (alu_rd_addr != 0); m_addr = alu_rd_addr; m_data = alu_rd_data;
      end else if (gl) begin
        m_last = 1; m_we = (lsu_rd_addr != 0); m_addr = lsu_rd_addr; m_data = lsu_rd_data;
      end else begin
        m_we = 1'b0;
      end
    end
  endtask

  task automatic tick();
    m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    alu_valid = 1'b1; alu_rd_addr = 5'd1; alu_rd_data = 32'h1111_1111;
    lsu_valid = 1'b1; lsu_rd_addr = 5'd5; lsu_rd_data = 32'h5555_5555;
`ifdef WB_FWD_EN
    rs1_addr = '0; rs2_addr = '0;
`endif
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      nchk++; if (alu_ready !== 1'b0) $display("FAIL reset_alu_ready got %0b expected 0", alu_ready); else npass++;
      nchk++; if (lsu_ready !== 1'b0) $display("FAIL reset_lsu_ready got %0b expected 0", lsu_ready); else npass++;
      nchk++; if (rd_we !== 1'b0) $display("FAIL reset_rd_we got %0b expected 0", rd_we); else npass++;
      nchk++; if (rd_addr !== 5'd0) $display("FAIL reset_rd_addr got %0h expected 0", rd_addr); else npass++;
      nchk++; if (rd_data !== 32'd0) $display("FAIL reset_rd_data got %0h expected 0", rd_data); else npass++;
      tick();
    end
    rst_n = 1'b1;
    @(negedge clk);
    nchk++; if (lsu_ready !== 1'b1) $display("FAIL first_tie_lsu got %0b expected 1", lsu_ready); else npass++;
    nchk++; if (alu_ready !== 1'b0) $display("FAIL first_tie_alu got %0b expected 0", alu_ready); else npass++;
    tick();
    alu_valid = 1'b0; lsu_valid = 1'b0;
  endtask

  task automatic test_single_alu();
    alu_valid = 1'b1; alu_rd_addr = 5'd3; alu_rd_data = 32'hDEAD_BEEF;
    @(negedge clk);
    nchk++; if (alu_ready !== 1'b1) $display("FAIL single_alu_ready got %0b expected 1", alu_ready); else npass++;
    tick();
    alu_valid = 1'b0;
    @(negedge clk);
    nchk++; if (rd_we !== 1'b1) $display("FAIL single_rd_we got %0b expected 1", rd_we); else npass++;
    nchk++; if (rd_addr !== 5'd3) $display("FAIL single_rd_addr got %0h expected 3", rd_addr); else npass++;
    nchk++; if (rd_data !== 32'hDEAD_BEEF) $display("FAIL single_rd_data got %0h expected deadbeef", rd_data); else npass++;
    tick();
    @(negedge clk);
    nchk++; if (rd_we !== 1'b0) $display("FAIL single_idle_rd_we got %0b expected 0", rd_we); else npass++;
    tick();
  endtask

  task automatic test_contention();
    int exp_a [4] = '{5, 1, 6, 2};
    alu_valid = 1'b1; alu_rd_addr = 5'd1; alu_rd_data = 32'hA000_0001;
    lsu_valid = 1'b1; lsu_rd_addr = 5'd5; lsu_rd_data = 32'hB000_0005;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nchk++; if (lsu_ready !== ((i % 2) == 0)) $display("FAIL contention_lsu_ready[%0d] got %0b expected %0b", i, lsu_ready, (i % 2) == 0); else npass++;
      nchk++; if (alu_ready !== ((i % 2) == 1)) $display("FAIL contention_alu_ready[%0d] got %0b expected %0b", i, alu_ready, (i % 2) == 1); else npass++;
      if (i > 0) begin
        nchk++; if (rd_we !== 1'b1) $display("FAIL contention_rd_we[%0d] got %0b expected 1", i, rd_we); else npass++;
        nchk++; if (rd_addr !== exp_a[i-1][DEPTH-1:0]) $display("FAIL contention_rd_addr[%0d] got %0d expected %0d", i, rd_addr, exp_a[i-1]); else npass++;
      end
      tick();
      if ((i % 2) == 0) begin lsu_rd_addr = 5'd6; lsu_rd_data = 32'hB000_0006; end
      else begin alu_rd_addr = 5'd2; alu_rd_data = 32'hA000_0002; end
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    @(negedge clk);
    nchk++; if (rd_we !== 1'b1) $display("FAIL contention_last_we got %0b expected 1", rd_we); else npass++;
    nchk++; if (rd_addr !== 5'd2) $display("FAIL contention_last_addr got %0d expected 2", rd_addr); else npass++;
    nchk++; if (rd_data !== 32'hA000_0002) $display("FAIL contention_last_data got %0h expected a0000002", rd_data); else npass++;
    tick();
  endtask

  task automatic test_x0();
    lsu_valid = 1'b1; lsu_rd_addr = 5'd0; lsu_rd_data = 32'h0000_1234;
    @(negedge clk);
    nchk++; if (lsu_ready !== 1'b1) $display("FAIL x0_lsu_ready got %0b expected 1", lsu_ready); else npass++;
    tick();
    lsu_valid = 1'b0;
    @(negedge clk);
    nchk++; if (rd_we !== 1'b0) $display("FAIL x0_rd_we got %0b expected 0", rd_we); else npass++;
    nchk++; if (rd_addr !== 5'd0) $display("FAIL x0_rd_addr got %0h expected 0", rd_addr); else npass++;
    nchk++; if (rd_data !== 32'h0000_1234) $display("FAIL x0_rd_data got %0h expected 1234", rd_data); else npass++;
    tick();
  endtask

  task automatic test_reset_mid();
    alu_valid = 1'b1; alu_rd_addr = 5'd9; alu_rd_data = 32'h0000_0009;
    tick();
    alu_rd_addr = 5'd10; alu_rd_data = 32'h0000_000A;
    rst_n = 1'b0;
    @(negedge clk);
    nchk++; if (alu_ready !== 1'b0) $display("FAIL midrst_alu_ready got %0b expected 0", alu_ready); else npass++;
    nchk++; if (rd_we !== 1'b1) $display("FAIL midrst_pending_we got %0b expected 1", rd_we); else npass++;
    tick();
    rst_n = 1'b1;
    lsu_valid = 1'b1; lsu_rd_addr = 5'd11; lsu_rd_data = 32'h0000_000B;
    @(negedge clk);
    nchk++; if (rd_we !== 1'b0) $display("FAIL midrst_rd_we got %0b expected 0", rd_we); else npass++;
    nchk++; if (lsu_ready !== 1'b1) $display("FAIL midrst_tie_lsu got %0b expected 1", lsu_ready); else npass++;
    nchk++; if (alu_ready !== 1'b0) $display("FAIL midrst_tie_alu got %0b expected 0", alu_ready); else npass++;
    tick();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    tick();
  endtask

`ifdef WB_FWD_EN
  task automatic test_fwd();
    alu_valid = 1'b1; alu_rd_addr = 5'd7; alu_rd_data = 32'hA5A5_A5A5;
    rs1_addr = 5'd7; rs2_addr = 5'd8;
    tick();
    alu_valid = 1'b0;
    tick();
    @(negedge clk);
    nchk++; if (fwd_rs1_hit !== 1'b1) $display("FAIL fwd_rs1_hit got %0b expected 1", fwd_rs1_hit); else npass++;
    nchk++; if (fwd_rs2_hit !== 1'b0) $display("FAIL fwd_rs2_hit got %0b expected 0", fwd_rs2_hit); else npass++;
    nchk++; if (fwd_data !== 32'hA5A5_A5A5) $display("FAIL fwd_data got %0h expected a5a5a5a5", fwd_data); else npass++;
    alu_valid = 1'b1; alu_rd_addr = 5'd0; alu_rd_data = 32'h5A5A_5A5A;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    tick();
    alu_valid = 1'b0;
    tick();
    @(negedge clk);
    nchk++; if (fwd_rs1_hit !== 1'b0) $display("FAIL fwd_x0_rs1_hit got %0b expected 0", fwd_rs1_hit); else npass++;
    nchk++; if (fwd_rs2_hit !== 1'b0) $display("FAIL fwd_x0_rs2_hit got %0b expected 0", fwd_rs2_hit); else npass++;
    tick();
  endtask
`endif

  task automatic test_random();
    logic a_acc, l_acc;
    alu_valid = 1'b0; lsu_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      if (!alu_valid) begin
        alu_valid   = ($urandom_range(0, 9) < 7);
        alu_rd_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : DEPTH'($urandom_range(1, 31));
        alu_rd_data = $urandom;
      end
      if (!lsu_valid) begin
        lsu_valid   = ($urandom_range(0, 9) < 7);
        lsu_rd_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : DEPTH'($urandom_range(1, 31));
        lsu_rd_data = $urandom;
      end
`ifdef WB_FWD_EN
      rs1_addr = ($urandom_range(0, 1) == 0) ? m_addr : DEPTH'($urandom_range(0, 31));
      rs2_addr = ($urandom_range(0, 2) == 0) ? m_addr : DEPTH'($urandom_range(0, 31));
`endif
      @(negedge clk);
      a_acc = m_alu_rdy();
      l_acc = m_lsu_rdy();
      nchk++; if (alu_ready !== a_acc) $display("FAIL rnd_alu_ready[%0d] got %0b expected %0b", i, alu_ready, a_acc); else npass++;
      nchk++; if (lsu_ready !== l_acc) $display("FAIL rnd_lsu_ready[%0d] got %0b expected %0b", i, lsu_ready, l_acc); else npass++;
      nchk++; if (rd_we !== m_we) $display("FAIL rnd_rd_we[%0d] got %0b expected %0b", i, rd_we, m_we); else npass++;
      nchk++; if (rd_addr !== m_addr) $display("FAIL rnd_rd_addr[%0d] got %0h expected %0h", i, rd_addr, m_addr); else npass++;
      nchk++; if (rd_data !== m_data) $display("FAIL rnd_rd_data[%0d] got %0h expected %0h", i, rd_data, m_data); else npass++;
`ifdef WB_FWD_EN
      nchk++; if (fwd_rs1_hit !== m_f1) $display("FAIL rnd_fwd_rs1[%0d] got %0b expected %0b", i, fwd_rs1_hit, m_f1); else npass++;
      nchk++; if (fwd_rs2_hit !== m_f2) $display("FAIL rnd_fwd_rs2[%0d] got %0b expected %0b", i, fwd_rs2_hit, m_f2); else npass++;
      nchk++; if (fwd_data !== m_fd) $display("FAIL rnd_fwd_data[%0d] got %0h expected %0h", i, fwd_data, m_fd); else npass++;
`endif
      tick();
      if (a_acc) alu_valid = 1'b0;
      if (l_acc) lsu_valid = 1'b0;
    end
    rst_n = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0;
    tick();
  endtask

  initial begin
    m_last = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
`ifdef WB_FWD_EN
    m_f1 = 1'b0; m_f2 = 1'b0; m_fd = '0;
`endif
    test_reset();
    test_single_alu();
    test_contention();
    test_x0();
    test_reset_mid();
`ifdef WB_FWD_EN
    test_fwd();
`endif
    test_random();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
`default_nettype wire
